// File: rtl/breath_pwm_multi.sv
// Multi-channel breathing-LED PWM: prescaled tick, shared PWM period counter,
// triangle/sawtooth duty ramp and per-channel inversion.
module breath_pwm_multi #(
  parameter int CH      = 4,
  parameter int CLK_DIV = 50,
  parameter int PERIOD  = 1000,
  parameter int STEP    = 1,
  parameter int W       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] inv_mask,
  input  logic          hold,
  output logic [CH-1:0] pwm_out,
  output logic [W-1:0]  level,
  output logic          dir,
  output logic          cycle_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [W-1:0]  PC_LAST  = W'(PERIOD - 1);
  localparam logic [W-1:0]  FULL     = W'(PERIOD);
  localparam logic [W-1:0]  STEP_W   = W'(STEP);
  localparam logic [W:0]    FULL_X   = {1'b0, FULL};

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_FULL    = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_SAW     = 2'b11;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } ramp_dir_t;

  logic [PW-1:0] pre_r, pre_s;
  logic [W-1:0]  pc_r, pc_s;
  logic [W-1:0]  level_r, level_s;
  ramp_dir_t     dir_r, dir_s;
  logic          cycle_done_r, cycle_done_s;
  logic [CH-1:0] pwm_r, pwm_s;

  logic          tick_s;
  logic          pend_s;
  logic          raw_s;
  logic [W:0]    up_sum_s;

  // prescaler and PWM period counter, cleared while disabled
  always_comb begin
    tick_s = en && (pre_r == PRE_LAST);
    pend_s = tick_s && (pc_r == PC_LAST);
    pre_s  = pre_r;
    pc_s   = pc_r;
    if (!en) begin
      pre_s = '0;
      pc_s  = '0;
    end else if (tick_s) begin
      pre_s = '0;
      if (pend_s) begin
        pc_s = '0;
      end else begin
        pc_s = pc_r + W'(1);
      end
    end else begin
      pre_s = pre_r + PW'(1);
      pc_s  = pc_r;
    end
  end

  // duty ramp and ramp direction state; one extra bit keeps level+STEP exact
  always_comb begin
    up_sum_s     = {1'b0, level_r} + {1'b0, STEP_W};
    level_s      = level_r;
    dir_s        = dir_r;
    cycle_done_s = 1'b0;
    if (!en) begin
      level_s = '0;
      dir_s   = DIR_UP;
    end else if (pend_s && !hold && mode[1]) begin
      case (mode)
        MODE_BREATHE: begin
          case (dir_r)
            DIR_UP: begin
              if (up_sum_s >= FULL_X) begin
                level_s = FULL;
                dir_s   = DIR_DOWN;
              end else begin
                level_s = up_sum_s[W-1:0];
              end
            end
            DIR_DOWN: begin
              if (level_r <= STEP_W) begin
                level_s      = '0;
                dir_s        = DIR_UP;
                cycle_done_s = 1'b1;
              end else begin
                level_s = level_r - STEP_W;
              end
            end
            default: begin
              level_s = level_r;
              dir_s   = DIR_UP;
            end
          endcase
        end
        MODE_SAW: begin
          dir_s = DIR_UP;
          if (level_r == FULL) begin
            level_s      = '0;
            cycle_done_s = 1'b1;
          end else if (up_sum_s > FULL_X) begin
            level_s = FULL;
          end else begin
            level_s = up_sum_s[W-1:0];
          end
        end
        default: begin
          level_s = level_r;
          dir_s   = dir_r;
        end
      endcase
    end else begin
      level_s = level_r;
      dir_s   = dir_r;
    end
  end

  // raw compare and per-channel output; off mode and disable override inversion
  always_comb begin
    case (mode)
      MODE_OFF:  raw_s = 1'b0;
      MODE_FULL: raw_s = 1'b1;
      default:   raw_s = (pc_r < level_r);
    endcase
    if (en && (mode != MODE_OFF)) begin
      pwm_s = {CH{raw_s}} ^ inv_mask;
    end else begin
      pwm_s = '0;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r        <= '0;
      pc_r         <= '0;
      level_r      <= '0;
      dir_r        <= DIR_UP;
      cycle_done_r <= 1'b0;
      pwm_r        <= '0;
    end else begin
      pre_r        <= pre_s;
      pc_r         <= pc_s;
      level_r      <= level_s;
      dir_r        <= dir_s;
      cycle_done_r <= cycle_done_s;
      pwm_r        <= pwm_s;
    end
  end

  assign pwm_out    = pwm_r;
  assign level      = level_r;
  assign dir        = dir_r;
  assign cycle_done = cycle_done_r;

endmodule

// File: tb/tb_breath_pwm_multi.sv
// Self-checking bench for breath_pwm_multi: directed scenarios plus random
// stimulus, two instances (STEP=1 and STEP=3) against a phase-based model.
module tb_breath_pwm_multi;

  localparam int CH      = 4;
  localparam int CLK_DIV = 2;
  localparam int PERIOD  = 4;
  localparam int W       = 11;
  localparam int PLEN    = CLK_DIV * PERIOD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          hold = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [CH-1:0] inv_mask = '0;

  logic [CH-1:0] pwm_a, pwm_b;
  logic [W-1:0]  level_a, level_b;
  logic          dir_a, dir_b, cd_a, cd_b;

  always #5 clk = ~clk;

  breath_pwm_multi #(.CH(CH), .CLK_DIV(CLK_DIV), .PERIOD(PERIOD), .STEP(1), .W(W)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inv_mask(inv_mask), .hold(hold),
    .pwm_out(pwm_a), .level(level_a), .dir(dir_a), .cycle_done(cd_a));

  breath_pwm_multi #(.CH(CH), .CLK_DIV(CLK_DIV), .PERIOD(PERIOD), .STEP(3), .W(W)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inv_mask(inv_mask), .hold(hold),
    .pwm_out(pwm_b), .level(level_b), .dir(dir_b), .cycle_done(cd_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: n is the clk phase within a PWM period since the last clear
  int            n;
  int            steps [2] = '{1, 3};
  int            m_level [2];
  bit            m_dir [2];
  bit            m_cd [2];
  logic [CH-1:0] m_pwm [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < 2; k++) begin
      m_level[k] = 0;
      m_dir[k]   = 1'b1;
      m_cd[k]    = 1'b0;
      m_pwm[k]   = '0;
    end
  endtask

  task automatic model_edge();
    int pc;
    bit pend;
    bit raw;
    int s;
    if (!rst_n || !en) begin
      model_reset();
    end else begin
      pc   = n / CLK_DIV;
      pend = (n == PLEN - 1);
      for (int k = 0; k < 2; k++) begin
        if (mode == 2'b01) raw = 1'b1;
        else raw = (pc < m_level[k]);
        m_pwm[k] = (mode == 2'b00) ? '0 : ({CH{raw}} ^ inv_mask);
        m_cd[k]  = 1'b0;
        if (pend && !hold && mode[1]) begin
          s = steps[k];
          if (mode == 2'b11) begin
            m_dir[k] = 1'b1;
            if (m_level[k] == PERIOD) begin
              m_level[k] = 0;
              m_cd[k]    = 1'b1;
            end else begin
              m_level[k] = (m_level[k] + s > PERIOD) ? PERIOD : m_level[k] + s;
            end
          end else if (m_dir[k]) begin
            if (m_level[k] + s >= PERIOD) begin
              m_level[k] = PERIOD;
              m_dir[k]   = 1'b0;
            end else begin
              m_level[k] = m_level[k] + s;
            end
          end else begin
            if (m_level[k] <= s) begin
              m_level[k] = 0;
              m_dir[k]   = 1'b1;
              m_cd[k]    = 1'b1;
            end else begin
              m_level[k] = m_level[k] - s;
            end
          end
        end
      end
      n = (n + 1) % PLEN;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_val("pwm_a", pwm_a, m_pwm[0]);
    check_val("level_a", level_a, m_level[0]);
    check_val("dir_a", dir_a, m_dir[0]);
    check_val("cd_a", cd_a, m_cd[0]);
    check_val("pwm_b", pwm_b, m_pwm[1]);
    check_val("level_b", level_b, m_level[1]);
    check_val("dir_b", dir_b, m_dir[1]);
    check_val("cd_b", cd_b, m_cd[1]);
  endtask

  task automatic run_period(output int hi, output int cds);
    hi  = 0;
    cds = 0;
    repeat (PLEN) begin
      cycle();
      hi  += int'(pwm_a[0]);
      cds += int'(cd_a);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_pwm_a", pwm_a, 0);
    check_val("rst_level_a", level_a, 0);
    check_val("rst_dir_a", dir_a, 1);
    check_val("rst_cd_a", cd_a, 0);
    check_val("rst_level_b", level_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, cds, first_cd, bound;
    int exp_hi [9]    = '{0, 2, 4, 6, 8, 6, 4, 2, 0};
    int exp_lvl_a [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
    int exp_lvl_b [9] = '{3, 4, 1, 0, 3, 4, 1, 0, 3};
    int exp_saw [10]  = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    int frozen;

    model_reset();
    en = 1'b1;
    mode = 2'b10;
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (20) cycle();

    // reset mid-run, then breathe from a clean start
    async_reset();
    first_cd = 0;
    for (int p = 0; p < 9; p++) begin
      run_period(hi, cds);
      check_val("breathe_hi", hi, exp_hi[p]);
      check_val("breathe_lvl_a", level_a, exp_lvl_a[p]);
      check_val("breathe_lvl_b", level_b, exp_lvl_b[p]);
      check_val("breathe_cd_b", cd_b, (exp_lvl_b[p] == 0) ? 1 : 0);
      check_val("breathe_cd_a", cd_a, (exp_lvl_a[p] == 0) ? 1 : 0);
      if (p == 3) check_val("breathe_dir_top", dir_a, 0);
      if (p == 7) first_cd = cyc;
    end
    bound = 0;
    do begin
      cycle();
      bound++;
    end while (!cd_a && bound < 100);
    check_val("cd_interval", cyc - first_cd, 64);

    // inversion, off, steady full
    inv_mask = 4'b1010;
    repeat (2 * PLEN) cycle();
    mode = 2'b00;
    cycle();
    check_val("off_pwm", pwm_a, 0);
    frozen = m_level[0];
    repeat (2 * PLEN) cycle();
    check_val("off_frozen", level_a, frozen);
    mode = 2'b01;
    cycle();
    check_val("full_inv_pwm", pwm_a, 4'b0101);
    repeat (PLEN) cycle();

    // hold at level 2 on the way up
    mode = 2'b10;
    inv_mask = '0;
    bound = 0;
    do begin
      cycle();
      bound++;
    end while (!(m_level[0] == 2 && m_dir[0] && n == 0) && bound < 400);
    check_val("hold_reach", (bound < 400) ? 1 : 0, 1);
    hold = 1'b1;
    for (int p = 0; p < 5; p++) begin
      run_period(hi, cds);
      check_val("hold_hi", hi, 4);
      check_val("hold_lvl", level_a, 2);
    end
    hold = 1'b0;
    run_period(hi, cds);
    check_val("unhold_lvl1", level_a, 3);
    run_period(hi, cds);
    check_val("unhold_lvl2", level_a, 4);

    // sawtooth from level 4
    mode = 2'b11;
    for (int p = 0; p < 10; p++) begin
      run_period(hi, cds);
      check_val("saw_lvl", level_a, exp_saw[p]);
      check_val("saw_dir", dir_a, 1);
      check_val("saw_cd", cd_a, (p == 0 || p == 5) ? 1 : 0);
    end

    // enable drop at level 3 going down
    mode = 2'b10;
    bound = 0;
    do begin
      cycle();
      bound++;
    end while (!(m_level[0] == 3 && !m_dir[0]) && bound < 400);
    check_val("endrop_reach", (bound < 400) ? 1 : 0, 1);
    en = 1'b0;
    cycle();
    check_val("endrop_lvl", level_a, 0);
    check_val("endrop_dir", dir_a, 1);
    check_val("endrop_pwm", pwm_a, 0);
    en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      run_period(hi, cds);
      check_val("reen_lvl", level_a, p + 1);
    end

    // random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 31) == 0) inv_mask = CH'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
